// File: rtl/global_sram_dma.sv
// Single-command burst engine for the global SRAM macro. Read bursts stream out
// through a 2-entry skid FIFO; write bursts sink a valid/ready stream.
`ifndef ARR_GBUS_DATA
`define ARR_GBUS_DATA 32
`endif
`ifndef GLOBAL_SRAM_DEPTH
`define GLOBAL_SRAM_DEPTH 1024
`endif

module global_sram_dma #(
  parameter int unsigned DATA_BIT = `ARR_GBUS_DATA,
  parameter int unsigned DEPTH    = `GLOBAL_SRAM_DEPTH,
  localparam int unsigned AW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [AW-1:0]       cmd_len,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_BIT-1:0] rd_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_BIT-1:0] wr_data,
  output logic [AW-1:0]       sram_addr,
  output logic                sram_wen,
  output logic [DATA_BIT-1:0] sram_wdata,
  output logic                sram_ren,
  input  logic [DATA_BIT-1:0] sram_rdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state;
  logic [AW-1:0]       base;
  logic [AW-1:0]       len;
  logic [AW-1:0]       issued;
  logic [AW-1:0]       written;
  logic [DATA_BIT-1:0] fifo_q [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          fifo_count;
  logic                inflight;

  logic                pop;
  logic [2:0]          occ;
  logic [AW:0]         cmd_end;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_valid  = (fifo_count != 2'd0);
  assign rd_data   = fifo_q[rd_ptr];
  assign cmd_end   = {1'b0, cmd_addr} + {1'b0, cmd_len};

  // Words already committed to the FIFO after this cycle's pop; ren only if a slot stays free.
  always_comb begin
    pop        = rd_valid & rd_ready;
    occ        = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    sram_ren   = (state == READ) && (issued < len) && (occ < 3'd2);
    wr_ready   = (state == WRITE) && (written < len);
    sram_wen   = wr_ready & wr_valid;
    sram_wdata = '0;
    sram_addr  = '0;
    if (sram_ren) begin
      sram_addr = base + issued;
    end else if (sram_wen) begin
      sram_addr  = base + written;
      sram_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      issued     <= '0;
      written    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      inflight   <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      err      <= 1'b0;
      inflight <= sram_ren;
      if (sram_ren) issued  <= issued + AW'(1);
      if (sram_wen) written <= written + AW'(1);

      // SRAM data lands one cycle after ren; capture it into the tail slot.
      if (inflight) begin
        fifo_q[wr_ptr] <= sram_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(inflight) - 2'(pop);

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_end > (AW + 1)'(DEPTH)) begin
              err <= 1'b1;
            end else if (cmd_len == '0) begin
              state <= DONE;
            end else begin
              base    <= cmd_addr;
              len     <= cmd_len;
              issued  <= '0;
              written <= '0;
              state   <= cmd_write ? WRITE : READ;
            end
          end
        end
        READ: begin
          if ((issued == len) && !inflight && (fifo_count == 2'd0)) state <= DONE;
        end
        WRITE: begin
          if (sram_wen && ((written + AW'(1)) == len)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
